mux_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one 8:1 mux datapath (mux81) among 8 requesters.
//  - Drives the mux select lines {A,B,C} and holds each grant for a settle window.
//  - Samples the mux output Y into a per-channel capture register.
//  - Scan mode sweeps all 8 selects in order to read back a full truth table
//    (e.g. the t1mux81 / t2mux81 tables) in one command.

---
 rtl/mux_rr_sched_pkg.sv | 6 +
 rtl/mux_rr_sched_if.sv | 19 +
 rtl/mux_rr_pick.sv | 14 +
 rtl/mux_rr_sched.sv | 71 +++++++
 tb/tb_mux_rr_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_sched_pkg.sv
// mux_rr_sched_pkg: shared FSM state encoding and channel/select widths for mux-sharing controllers
package mux_rr_sched_pkg;
  localparam int N_CH = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/mux_rr_sched_if.sv
// mux_rr_sched_if: scheduler bus; slave=scheduler (in req,scan_start,mux_y; out sel,grant,busy,sample_valid,sample_ch,sample_data,captured,scan_done), master=requester/parent
interface mux_rr_sched_if;
  import mux_rr_sched_pkg::*;
  logic [N_CH-1:0] req;
  logic scan_start;
  logic mux_y;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0] grant;
  logic busy;
  logic sample_valid;
  logic [SEL_W-1:0] sample_ch;
  logic sample_data;
  logic [N_CH-1:0] captured;
  logic scan_done;
  modport master(output req, scan_start, mux_y,
                 input sel, grant, busy, sample_valid, sample_ch, sample_data, captured, scan_done);
  modport slave(input req, scan_start, mux_y,
                output sel, grant, busy, sample_valid, sample_ch, sample_data, captured, scan_done);
endinterface

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: rotating priority encoder; in req[7:0], ptr[2:0]; out any, idx = first set req at or after ptr (wrapping)
module mux_rr_pick import mux_rr_sched_pkg::*; (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    any = |req;
    idx = ptr;
    for (int i = N_CH - 1; i >= 0; i--)
      if (req[ptr + SEL_W'(i)]) idx = ptr + SEL_W'(i);
  end
endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin/scan scheduler for a shared 8:1 mux; ports clk, rst (sync, active-high), bus (slave modport of mux_rr_sched_if)
module mux_rr_sched import mux_rr_sched_pkg::*; #(
  parameter int HOLD_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  mux_rr_sched_if.slave bus
);
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("mux_rr_sched: HOLD_CYCLES must be in 1..255");
  end
  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);
  state_t state;
  logic scan;
  logic [SEL_W-1:0] ptr;
  logic [7:0] cnt;
  logic any;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] start_ch;
  mux_rr_pick u_pick (.req(bus.req), .ptr(ptr), .any(any), .idx(idx));
  assign start_ch = bus.scan_start ? '0 : idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scan <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      bus.sel <= '0;
      bus.grant <= '0;
      bus.busy <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.sample_ch <= '0;
      bus.sample_data <= 1'b0;
      bus.captured <= '0;
      bus.scan_done <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.scan_done <= 1'b0;
      if (state == IDLE) begin
        if (bus.scan_start || any) begin
          scan <= bus.scan_start;
          bus.sel <= start_ch;
          bus.grant <= N_CH'(1) << start_ch;
          bus.busy <= 1'b1;
          cnt <= RELOAD;
          state <= HOLD;
        end
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end else begin
        // sel doubles as the current channel while a grant is active
        bus.captured[bus.sel] <= bus.mux_y;
        bus.sample_valid <= 1'b1;
        bus.sample_ch <= bus.sel;
        bus.sample_data <= bus.mux_y;
        if (scan && bus.sel != SEL_W'(N_CH - 1)) begin
          bus.sel <= bus.sel + 1'b1;
          bus.grant <= bus.grant << 1;
          cnt <= RELOAD;
        end else begin
          bus.scan_done <= scan;
          scan <= 1'b0;
          if (!scan) ptr <= bus.sel + 1'b1;
          bus.grant <= '0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: directed self-checking bench for mux_rr_sched with a behavioural mux81
module tb_mux_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] v = 8'h00;
  int checks = 0;
  int errors = 0;
  mux_rr_sched_if bus();
  mux_rr_sched #(.HOLD_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.mux_y = v[bus.sel];
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.req = 8'h00;
    bus.scan_start = 1'b0;
    tick;
    tick;
    checks++;
    if (bus.grant !== 8'h00 || bus.sel !== 3'd0 || bus.captured !== 8'h00 || bus.busy !== 1'b0 ||
        bus.sample_valid !== 1'b0 || bus.scan_done !== 1'b0) begin
      errors++;
      $display("FAIL reset got grant=%h sel=%0d cap=%h busy=%b sv=%b sd=%b want all 0",
               bus.grant, bus.sel, bus.captured, bus.busy, bus.sample_valid, bus.scan_done);
    end
    rst = 1'b0;
  endtask
  task automatic test_single;
    v = 8'h20;
    bus.req = 8'h20;
    tick;
    bus.req = 8'h00;
    checks++;
    if (bus.grant !== 8'h20 || bus.sel !== 3'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got grant=%h sel=%0d busy=%b want 20 5 1", bus.grant, bus.sel, bus.busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (bus.sample_valid !== 1'b0 || bus.grant !== 8'h20) begin
        errors++;
        $display("FAIL single_hold%0d got sv=%b grant=%h want 0 20", k, bus.sample_valid, bus.grant);
      end
    end
    tick;
    checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 3'd5 || bus.sample_data !== 1'b1 ||
        bus.captured !== 8'h20 || bus.grant !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_sample got sv=%b ch=%0d d=%b cap=%h grant=%h busy=%b want 1 5 1 20 00 0",
               bus.sample_valid, bus.sample_ch, bus.sample_data, bus.captured, bus.grant, bus.busy);
    end
    tick;
    checks++;
    if (bus.sample_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got sv=%b busy=%b want 0 0", bus.sample_valid, bus.busy);
    end
  endtask
  task automatic test_round_robin;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    v = 8'hA5;
    bus.req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      int c = n % 8;
      tick;
      checks++;
      if (bus.grant !== 8'(1 << c) || bus.sel !== 3'(c)) begin
        errors++;
        $display("FAIL rr_grant%0d got grant=%h sel=%0d want %h %0d", n, bus.grant, bus.sel, 8'(1 << c), c);
      end
      for (int k = 0; k < 3; k++) tick;
      checks++;
      if (bus.sample_valid !== 1'b0 || bus.grant !== 8'(1 << c)) begin
        errors++;
        $display("FAIL rr_width%0d got sv=%b grant=%h want 0 %h", n, bus.sample_valid, bus.grant, 8'(1 << c));
      end
      tick;
      checks++;
      if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 3'(c) || bus.sample_data !== v[c] || bus.grant !== 8'h00) begin
        errors++;
        $display("FAIL rr_sample%0d got sv=%b ch=%0d d=%b grant=%h want 1 %0d %b 00",
                 n, bus.sample_valid, bus.sample_ch, bus.sample_data, bus.grant, c, v[c]);
      end
    end
    bus.req = 8'h00;
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== 8'h00) begin
      errors++;
      $display("FAIL rr_idle got busy=%b grant=%h want 0 00", bus.busy, bus.grant);
    end
  endtask
  task automatic test_wrap;
    int exp_ch[3] = '{6, 7, 1};
    v = 8'h80;
    for (int n = 0; n < 3; n++) begin
      bus.req = (n == 0) ? 8'h40 : 8'h82;
      tick;
      checks++;
      if (bus.grant !== 8'(1 << exp_ch[n])) begin
        errors++;
        $display("FAIL wrap_grant%0d got %h want %h", n, bus.grant, 8'(1 << exp_ch[n]));
      end
      for (int k = 0; k < 4; k++) tick;
      checks++;
      if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 3'(exp_ch[n]) || bus.sample_data !== v[exp_ch[n]]) begin
        errors++;
        $display("FAIL wrap_sample%0d got sv=%b ch=%0d d=%b want 1 %0d %b",
                 n, bus.sample_valid, bus.sample_ch, bus.sample_data, exp_ch[n], v[exp_ch[n]]);
      end
    end
    bus.req = 8'h00;
    tick;
  endtask
  task automatic test_scan;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    v = 8'b1001_0110;
    bus.req = 8'h08;
    bus.scan_start = 1'b1;
    tick;
    bus.scan_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (bus.grant !== 8'(1 << c) || bus.sel !== 3'(c) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL scan_grant%0d got grant=%h sel=%0d busy=%b want %h %0d 1",
                 c, bus.grant, bus.sel, bus.busy, 8'(1 << c), c);
      end
      for (int k = 0; k < 3; k++) begin
        if (c == 3 && k == 0) bus.scan_start = 1'b1;
        tick;
        bus.scan_start = 1'b0;
      end
      checks++;
      if (bus.sample_valid !== 1'b0 || bus.scan_done !== 1'b0) begin
        errors++;
        $display("FAIL scan_quiet%0d got sv=%b sd=%b want 0 0", c, bus.sample_valid, bus.scan_done);
      end
      tick;
      checks++;
      if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 3'(c) || bus.sample_data !== v[c] ||
          bus.scan_done !== (c == 7)) begin
        errors++;
        $display("FAIL scan_sample%0d got sv=%b ch=%0d d=%b sd=%b want 1 %0d %b %b",
                 c, bus.sample_valid, bus.sample_ch, bus.sample_data, bus.scan_done, c, v[c], c == 7);
      end
    end
    checks++;
    if (bus.captured !== 8'h96 || bus.grant !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL scan_end got cap=%h grant=%h busy=%b want 96 00 0", bus.captured, bus.grant, bus.busy);
    end
    tick;
    checks++;
    if (bus.grant !== 8'h08 || bus.sample_valid !== 1'b0 || bus.scan_done !== 1'b0) begin
      errors++;
      $display("FAIL scan_then_req got grant=%h sv=%b sd=%b want 08 0 0", bus.grant, bus.sample_valid, bus.scan_done);
    end
    bus.req = 8'h00;
    for (int k = 0; k < 4; k++) tick;
    checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 3'd3 || bus.sample_data !== 1'b0) begin
      errors++;
      $display("FAIL scan_req_sample got sv=%b ch=%0d d=%b want 1 3 0", bus.sample_valid, bus.sample_ch, bus.sample_data);
    end
  endtask
  task automatic test_reset_mid;
    v = 8'h02;
    bus.req = 8'h04;
    tick;
    checks++;
    if (bus.grant !== 8'h04) begin
      errors++;
      $display("FAIL mid_grant got %h want 04", bus.grant);
    end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.req = 8'h00;
    checks++;
    if (bus.grant !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0 || bus.captured !== 8'h00 ||
        bus.sample_valid !== 1'b0 || bus.sample_ch !== 3'd0 || bus.sample_data !== 1'b0 || bus.scan_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got grant=%h sel=%0d busy=%b cap=%h sv=%b ch=%0d d=%b sd=%b want all 0",
               bus.grant, bus.sel, bus.busy, bus.captured, bus.sample_valid, bus.sample_ch, bus.sample_data, bus.scan_done);
    end
    bus.req = 8'h22;
    tick;
    checks++;
    if (bus.grant !== 8'h02) begin
      errors++;
      $display("FAIL mid_ptr got grant=%h want 02", bus.grant);
    end
    bus.req = 8'h00;
    for (int k = 0; k < 3; k++) tick;
    checks++;
    if (bus.grant !== 8'h02 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_hold got grant=%h busy=%b want 02 1", bus.grant, bus.busy);
    end
    tick;
    checks++;
    if (bus.sample_valid !== 1'b1 || bus.sample_ch !== 3'd1 || bus.sample_data !== 1'b1 || bus.captured !== 8'h02) begin
      errors++;
      $display("FAIL drop_sample got sv=%b ch=%0d d=%b cap=%h want 1 1 1 02",
               bus.sample_valid, bus.sample_ch, bus.sample_data, bus.captured);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_wrap;
    test_scan;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
